// File: rtl/vending_pkg.sv
// Shared encodings and default pricing for the vending machine service protocol
// and its customer-side driver.
package vending_pkg;

    localparam logic [1:0] SERVICE_OFF  = 2'd0;
    localparam logic [1:0] SERVICE_ON   = 2'd1;
    localparam logic [1:0] SERVICE_BUSY = 2'd2;

    localparam logic NTD_5 = 1'b0;
    localparam logic NTD_1 = 1'b1;

    localparam logic ITEM_NONE = 1'b0;
    localparam logic ITEM_A    = 1'b1;

    localparam logic [1:0] VALUE_NTD_5 = 2'd2;
    localparam logic [1:0] VALUE_NTD_1 = 2'd1;
    localparam logic [1:0] COST_A      = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ON  = 3'd1,
        DRIVE    = 3'd2,
        WAIT_OFF = 3'd3,
        REPORT   = 3'd4
    } cust_state_e;

endpackage

// File: rtl/vending_change_checker.sv
// Values the coins returned by the machine and compares them against what the
// customer should get back for the amount paid and the item delivered.
module vending_change_checker #(
    parameter logic [1:0] COST_A      = vending_pkg::COST_A,
    parameter logic [1:0] VALUE_NTD_5 = vending_pkg::VALUE_NTD_5,
    parameter logic [1:0] VALUE_NTD_1 = vending_pkg::VALUE_NTD_1
) (
    input  logic [2:0] i_paid,
    input  logic       i_coin5,
    input  logic       i_coin1,
    input  logic       i_item,
    output logic [2:0] o_change,
    output logic [2:0] o_expected,
    output logic       o_error
);
    import vending_pkg::*;

    logic [2:0] w_cost;
    logic       w_item_a;
    logic       w_short;

    assign w_cost   = {1'b0, COST_A};
    assign w_item_a = (i_item == ITEM_A);
    assign w_short  = (i_paid < w_cost);

    assign o_change = ({3{i_coin5}} & {1'b0, VALUE_NTD_5})
                    + ({3{i_coin1}} & {1'b0, VALUE_NTD_1});

    // Underpaying for a delivered item is flagged separately, so expected never wraps.
    assign o_expected = !w_item_a ? i_paid : (w_short ? 3'd0 : i_paid - w_cost);

    assign o_error = (o_change != o_expected) || (w_item_a && w_short);

endmodule

// File: rtl/vending_customer.sv
// Customer-side driver/checker: runs one purchase per command against the
// vending machine, checks the returned change and keeps saturating counters.
module vending_customer #(
    parameter logic [1:0] COST_A      = vending_pkg::COST_A,
    parameter logic [1:0] VALUE_NTD_5 = vending_pkg::VALUE_NTD_5,
    parameter logic [1:0] VALUE_NTD_1 = vending_pkg::VALUE_NTD_1,
    parameter logic [3:0] TIMEOUT     = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic       cmdNTD_5,
    input  logic       cmdNTD_1,
    input  logic       cmdItem,
    output logic       coinInNTD_5,
    output logic       coinInNTD_1,
    output logic       itemTypeIn,
    input  logic       coinOutNTD_5,
    input  logic       coinOutNTD_1,
    input  logic       itemTypeOut,
    input  logic [1:0] serviceTypeOut,
    output logic       doneValid,
    output logic       doneItem,
    output logic [1:0] doneChange,
    output logic       doneError,
    output logic       doneTimeout,
    output logic [3:0] purchaseCount,
    output logic [3:0] errorCount
);
    import vending_pkg::*;

    // IDLE accept cmd | WAIT_ON await ON | DRIVE coins one cycle | WAIT_OFF await OFF | REPORT strobe result
    cust_state_e r_state, w_state_nxt;

    logic       r_n5, r_n1, r_item;
    logic [3:0] r_tmo_cnt;
    logic       r_coin5, r_coin1, r_item_in;
    logic       r_done_item, r_done_error, r_done_timeout;
    logic [1:0] r_done_change;
    logic [3:0] r_purch_cnt, r_err_cnt;

    logic [2:0] w_paid, w_change, w_unused_expected;
    logic       w_chk_error, w_tmo_hit;
    logic       w_res_item, w_res_error, w_res_timeout;
    logic [1:0] w_res_change;

    assign w_paid = ({3{r_n5}} & {1'b0, VALUE_NTD_5}) + ({3{r_n1}} & {1'b0, VALUE_NTD_1});
    assign w_tmo_hit = ((r_tmo_cnt + 4'd1) == TIMEOUT);

    vending_change_checker #(
        .COST_A      (COST_A),
        .VALUE_NTD_5 (VALUE_NTD_5),
        .VALUE_NTD_1 (VALUE_NTD_1)
    ) u_checker (
        .i_paid     (w_paid),
        .i_coin5    (coinOutNTD_5),
        .i_coin1    (coinOutNTD_1),
        .i_item     (itemTypeOut),
        .o_change   (w_change),
        .o_expected (w_unused_expected),
        .o_error    (w_chk_error)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_res_item    = 1'b0;
        w_res_change  = 2'd0;
        w_res_error   = 1'b0;
        w_res_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmdValid) w_state_nxt = (cmdItem == ITEM_NONE) ? REPORT : WAIT_ON;
            end
            WAIT_ON: begin
                if (w_tmo_hit) begin
                    w_state_nxt   = REPORT;
                    w_res_error   = 1'b1;
                    w_res_timeout = 1'b1;
                end else if (serviceTypeOut == SERVICE_ON) begin
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: w_state_nxt = WAIT_OFF;
            WAIT_OFF: begin
                // A completion seen on the last allowed cycle still counts.
                if (serviceTypeOut == SERVICE_OFF) begin
                    w_state_nxt  = REPORT;
                    w_res_item   = (itemTypeOut == ITEM_A);
                    w_res_change = w_change[2] ? 2'd3 : w_change[1:0];
                    w_res_error  = w_chk_error;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = REPORT;
                    w_res_error   = 1'b1;
                    w_res_timeout = 1'b1;
                end
            end
            REPORT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_n5           <= 1'b0;
            r_n1           <= 1'b0;
            r_item         <= 1'b0;
            r_tmo_cnt      <= 4'd0;
            r_coin5        <= 1'b0;
            r_coin1        <= 1'b0;
            r_item_in      <= 1'b0;
            r_done_item    <= 1'b0;
            r_done_change  <= 2'd0;
            r_done_error   <= 1'b0;
            r_done_timeout <= 1'b0;
            r_purch_cnt    <= 4'd0;
            r_err_cnt      <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && cmdValid) begin
                r_n5      <= cmdNTD_5;
                r_n1      <= cmdNTD_1;
                r_item    <= cmdItem;
                r_tmo_cnt <= 4'd0;
            end else if (r_state == WAIT_ON || r_state == WAIT_OFF) begin
                r_tmo_cnt <= r_tmo_cnt + 4'd1;
            end
            r_coin5   <= (w_state_nxt == DRIVE) ? r_n5   : 1'b0;
            r_coin1   <= (w_state_nxt == DRIVE) ? r_n1   : 1'b0;
            r_item_in <= (w_state_nxt == DRIVE) ? r_item : 1'b0;
            if (w_state_nxt == REPORT) begin
                r_done_item    <= w_res_item;
                r_done_change  <= w_res_change;
                r_done_error   <= w_res_error;
                r_done_timeout <= w_res_timeout;
                if (w_res_item && !w_res_error && r_purch_cnt != 4'hF)
                    r_purch_cnt <= r_purch_cnt + 4'd1;
                if (w_res_error && r_err_cnt != 4'hF)
                    r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    assign cmdReady      = (r_state == IDLE);
    assign doneValid     = (r_state == REPORT);
    assign coinInNTD_5   = r_coin5;
    assign coinInNTD_1   = r_coin1;
    assign itemTypeIn    = r_item_in;
    assign doneItem      = r_done_item;
    assign doneChange    = r_done_change;
    assign doneError     = r_done_error;
    assign doneTimeout   = r_done_timeout;
    assign purchaseCount = r_purch_cnt;
    assign errorCount    = r_err_cnt;

endmodule
